// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcode and FSM state
// encodings, default latencies and small helpers used by mdu_ctrl/mdu_alu.
package mdu_ctrl_pkg;

    // Default busy latencies for the two multi-cycle operation classes
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // E-stage MDU opcode encoding (4-bit field from the decoder)
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // True for the opcodes that launch a multi-cycle operation
    function automatic logic is_start_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // Counter width large enough to hold the longer of the two latencies
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational 64-bit arithmetic for the MDU: signed/unsigned multiply and
// signed/unsigned divide. Result is packed as {HI, LO}; for divides HI holds
// the remainder and LO the quotient.
module mdu_alu
    import mdu_ctrl_pkg::*;
(
    input  md_op_e      i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [63:0] o_result,
    output logic        o_div_zero
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_udivisor;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [31:0] w_mag_quot;
    logic [31:0] w_mag_rem;
    logic [31:0] w_squot;
    logic [31:0] w_srem;

    // Products: sign-extend to 64 bits for signed, zero-extend for unsigned;
    // the low 64 bits of either product are exact.
    assign w_sprod = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
    assign w_uprod = {32'd0, i_rs} * {32'd0, i_rt};

    // A zero divisor is replaced by 1 so the datapath never divides by zero;
    // the controller discards the result anyway.
    assign o_div_zero = (i_rt == 32'd0);
    assign w_udivisor = o_div_zero ? 32'd1 : i_rt;
    assign w_uquot    = i_rs / w_udivisor;
    assign w_urem     = i_rs % w_udivisor;

    // Signed divide by magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. The most negative dividend has a
    // magnitude of 0x80000000, which is representable unsigned.
    assign w_abs_rs   = i_rs[31] ? (~i_rs + 32'd1) : i_rs;
    assign w_abs_rt   = i_rt[31] ? (~i_rt + 32'd1) : w_udivisor;
    assign w_mag_quot = w_abs_rs / w_abs_rt;
    assign w_mag_rem  = w_abs_rs % w_abs_rt;
    assign w_squot    = (i_rs[31] ^ i_rt[31]) ? (~w_mag_quot + 32'd1) : w_mag_quot;
    assign w_srem     = i_rs[31] ? (~w_mag_rem + 32'd1) : w_mag_rem;

    // Select the result for the requested operation; zero for anything else
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        o_result = 64'd0;
        case (i_op)
            MD_MULT:  o_result = w_sprod;
            MD_MULTU: o_result = w_uprod;
            MD_DIV:   o_result = {w_srem, w_squot};
            MD_DIVU:  o_result = {w_urem, w_uquot};
            default:  o_result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller. Latches the arithmetic result at the
// start edge, holds busy for a fixed latency, then commits to HI/LO. Also
// handles MTHI/MTLO writes, MFHI/MFLO read data and the D-stage stall.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [63:0]      r_result;
    logic             r_div_zero;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    md_op_e           w_op;
    logic [63:0]      w_alu_result;
    logic             w_alu_div_zero;

    assign w_op = md_op_e'(E_md_op);

    mdu_alu u_alu (
        .i_op       (w_op),
        .i_rs       (E_rs),
        .i_rt       (E_rt),
        .o_result   (w_alu_result),
        .o_div_zero (w_alu_div_zero)
    );

    // FSM, latency counter, result register and HI/LO; new opcodes are only
    // accepted in IDLE, so anything arriving while busy is dropped.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_result   <= 64'd0;
            r_div_zero <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    case (w_op)
                        MD_MULT, MD_MULTU: begin
                            r_result   <= w_alu_result;
                            r_div_zero <= 1'b0;
                            r_cnt      <= MULT_LOAD;
                            r_busy     <= 1'b1;
                            r_state    <= ST_MULT;
                        end
                        MD_DIV, MD_DIVU: begin
                            r_result   <= w_alu_result;
                            r_div_zero <= w_alu_div_zero;
                            r_cnt      <= DIV_LOAD;
                            r_busy     <= 1'b1;
                            r_state    <= ST_DIV;
                        end
                        MD_MTHI: r_hi <= E_rs;
                        MD_MTLO: r_lo <= E_rs;
                        default: ;
                    endcase
                end
                ST_MULT, ST_DIV: begin
                    if (r_cnt == CNT_ONE) begin
                        // A divide by zero still spends its latency but
                        // leaves the architectural registers untouched.
                        if (!(r_state == ST_DIV && r_div_zero)) begin
                            r_hi <= r_result[63:32];
                            r_lo <= r_result[31:0];
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data for MFHI/MFLO straight from the current HI/LO
    always_comb begin
        md_rdata = 32'd0;
        case (w_op)
            MD_MFHI: md_rdata = r_hi;
            MD_MFLO: md_rdata = r_lo;
            default: md_rdata = 32'd0;
        endcase
    end

    // Block the next MDU instruction on both the start cycle and busy cycles
    assign md_stall = D_is_md & (r_busy | is_start_op(w_op));

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a table of directed multiply/divide
// vectors plus hand-written sequences for stall, reset and busy corner cases.
module tb_mdu_ctrl;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam int         BUDGET   = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_md_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[$];

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .E_md_op  (E_md_op),
        .E_rs     (E_rs),
        .E_rt     (E_rt),
        .D_is_md  (D_is_md),
        .busy     (busy),
        .md_stall (md_stall),
        .md_rdata (md_rdata),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        E_md_op = op;
        E_rs    = val;
        step();
        E_md_op = OP_NONE;
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] op,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input int cycles);
        vec_t v;
        v.name = name; v.op = op; v.rs = rs; v.rt = rt;
        v.pre_hi = pre_hi; v.pre_lo = pre_lo;
        v.exp_hi = exp_hi; v.exp_lo = exp_lo; v.exp_cycles = cycles;
        return v;
    endfunction

    initial begin
        int          cycles;
        logic        saw_stall;
        logic        stall_ok;

        reset   = 1'b1;
        E_md_op = OP_NONE;
        E_rs    = 32'd0;
        E_rt    = 32'd0;
        D_is_md = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", {31'd0, md_stall}, 32'd0);
        reset = 1'b0;

        vecs.push_back(mk("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5));
        vecs.push_back(mk("divu_17_5", OP_DIVU,  32'd17,       32'd5,        32'hCAFE, 32'hBEEF, 32'd2,   32'd3,        10));
        vecs.push_back(mk("div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10));
        vecs.push_back(mk("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3, 32'h4, 32'hFFFFFFFE, 32'h00000001, 5));
        vecs.push_back(mk("div_zero",  OP_DIV,   32'h55,       32'd0,        32'h1234, 32'h5678, 32'h1234, 32'h5678,   10));
        vecs.push_back(mk("mult_7_m3", OP_MULT,  32'd7,        32'hFFFFFFFD, 32'h5, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFEB, 5));
        vecs.push_back(mk("div_7_m2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h7, 32'h8, 32'd1,        32'hFFFFFFFD, 10));
        vecs.push_back(mk("divu_big",  OP_DIVU,  32'hFFFFFFFF, 32'd2,        32'h9, 32'hA, 32'd1,        32'h7FFFFFFF, 10));
        vecs.push_back(mk("multu_hi",  OP_MULTU, 32'h80000000, 32'd2,        32'hB, 32'hC, 32'd1,        32'd0,        5));
        vecs.push_back(mk("div_m8_m3", OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hD, 32'hE, 32'hFFFFFFFE, 32'd2,        10));
        vecs.push_back(mk("divu_zero", OP_DIVU,  32'd5,        32'd0,        32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB,   10));

        // Table-driven vectors; D_is_md stays 0 so md_stall must never rise
        foreach (vecs[i]) begin
            mt(OP_MTHI, vecs[i].pre_hi);
            mt(OP_MTLO, vecs[i].pre_lo);
            E_md_op = vecs[i].op;
            E_rs    = vecs[i].rs;
            E_rt    = vecs[i].rt;
            #1;
            saw_stall = md_stall;
            step();
            E_md_op = OP_NONE;
            check({vecs[i].name, "_busy_start"}, {31'd0, busy}, 32'd1);
            check({vecs[i].name, "_hi_hold"}, hi, vecs[i].pre_hi);
            check({vecs[i].name, "_lo_hold"}, lo, vecs[i].pre_lo);
            cycles = 0;
            while (busy && cycles < BUDGET) begin
                saw_stall |= md_stall;
                step();
                cycles++;
            end
            check({vecs[i].name, "_cycles"}, 32'(cycles), 32'(vecs[i].exp_cycles));
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            check({vecs[i].name, "_no_stall"}, {31'd0, saw_stall}, 32'd0);
        end

        // MULT followed by MFLO waiting in D: stall on start and busy cycles
        E_md_op = OP_MULT;
        E_rs    = 32'd4;
        E_rt    = 32'd5;
        D_is_md = 1'b1;
        #1;
        check("stall_start", {31'd0, md_stall}, 32'd1);
        step();
        E_md_op  = OP_NONE;
        stall_ok = 1'b1;
        cycles   = 0;
        while (busy && cycles < BUDGET) begin
            #1;
            if (md_stall !== 1'b1) stall_ok = 1'b0;
            step();
            cycles++;
        end
        check("stall_busy_all", {31'd0, stall_ok}, 32'd1);
        check("stall_cycles", 32'(cycles), 32'd5);
        check("stall_release", {31'd0, md_stall}, 32'd0);
        E_md_op = OP_MFLO;
        D_is_md = 1'b0;
        #1;
        check("mflo_rdata", md_rdata, 32'd20);
        E_md_op = OP_MFHI;
        #1;
        check("mfhi_rdata", md_rdata, 32'd0);
        E_md_op = OP_NONE;
        #1;
        check("none_rdata", md_rdata, 32'd0);
        D_is_md = 1'b1;
        E_md_op = OP_MTLO;
        #1;
        check("mt_no_stall", {31'd0, md_stall}, 32'd0);
        E_md_op = OP_NONE;
        D_is_md = 1'b0;

        // MDU opcodes arriving while busy are ignored: no restart, no write
        E_md_op = OP_MULT; E_rs = 32'd2; E_rt = 32'd3;
        step();
        cycles = 0;
        E_md_op = OP_MULT; E_rs = 32'd100; E_rt = 32'd100;
        step(); cycles++;
        E_md_op = OP_MTHI; E_rs = 32'hDEAD;
        step(); cycles++;
        E_md_op = OP_DIV; E_rs = 32'd9; E_rt = 32'd1;
        step(); cycles++;
        E_md_op = OP_MTLO; E_rs = 32'hBEEF;
        step(); cycles++;
        E_md_op = OP_NONE;
        while (busy && cycles < BUDGET) begin
            step();
            cycles++;
        end
        check("ign_cycles", 32'(cycles), 32'd5);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd6);
        step();
        step();
        check("ign_no_restart", {31'd0, busy}, 32'd0);

        // Reset on the third busy cycle of a DIV abandons it
        mt(OP_MTHI, 32'hAA);
        mt(OP_MTLO, 32'hBB);
        E_md_op = OP_DIV; E_rs = 32'd100; E_rt = 32'd7;
        step();
        E_md_op = OP_NONE;
        step();
        step();
        check("rstdiv_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstdiv_busy", {31'd0, busy}, 32'd0);
        check("rstdiv_hi", hi, 32'd0);
        check("rstdiv_lo", lo, 32'd0);
        mt(OP_MTLO, 32'd9);
        check("rstdiv_mtlo", lo, 32'd9);
        check("rstdiv_mt_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 12; k++) step();
        check("rstdiv_lo_kept", lo, 32'd9);
        check("rstdiv_hi_kept", hi, 32'd0);

        // Reset wins over a simultaneous MTLO or start
        reset = 1'b1; E_md_op = OP_MTLO; E_rs = 32'd5;
        step();
        check("rst_over_mt", lo, 32'd0);
        E_md_op = OP_MULT; E_rs = 32'd3; E_rt = 32'd3;
        step();
        check("rst_over_start", {31'd0, busy}, 32'd0);
        reset = 1'b0; E_md_op = OP_NONE;
        step();
        check("rst_idle_after", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port E_md_op  input  4  E-stage MDU opcode: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-006 SHALL have port E_rs  input  32  forwarded rs operand in E.
REQ-007 SHALL have port E_rt  input  32  forwarded rt operand in E.
REQ-008 SHALL have port D_is_md  input  1  D-stage instruction is any MDU opcode.
REQ-009 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL have port md_stall  output  1  stall request to the hazard unit.
REQ-011 SHALL have port md_rdata  output  32  HI for MFHI, LO for MFLO, else 0.
REQ-012 SHALL have ports hi and lo  output  32 each  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, MULT, DIV, plus a down-counter of ceil(log2(DIV_CYCLES+1)) bits.
REQ-014 In IDLE, MULT/MULTU in E at edge N SHALL latch the 64-bit product (signed/unsigned) into an internal result register, enter MULT, and load the counter with MULT_CYCLES.
REQ-015 In IDLE, DIV/DIVU at edge N SHALL latch quotient to result-LO and remainder to result-HI (signed: quotient truncates toward zero, remainder takes dividend sign), enter DIV, and load the counter with DIV_CYCLES.
REQ-016 busy SHALL be 1 for exactly MULT_CYCLES (or DIV_CYCLES) cycles after the start edge; a start at edge N drives busy high from N through edge N+cycles.
REQ-017 When the counter reaches 1 in MULT/DIV, the next edge SHALL write the result to HI/LO, clear busy, and return to IDLE.
REQ-018 HI/LO SHALL keep their old values while busy; new values SHALL be visible on the cycle busy falls.
REQ-019 DIV/DIVU with E_rt = 0 SHALL still take DIV_CYCLES and SHALL leave HI and LO unchanged at completion.
REQ-020 MTHI/MTLO in IDLE SHALL write E_rs to HI/LO at the next edge, with no busy.
REQ-021 md_rdata SHALL be combinational from current hi/lo.
REQ-022 md_stall SHALL equal D_is_md & (busy | E_md_op is MULT/MULTU/DIV/DIVU), so start and busy cycles both block the next MDU instruction.
REQ-023 An MDU opcode arriving in E while busy is a hazard-unit fault; mdu_ctrl SHALL ignore it (no restart, no HI/LO write).
REQ-024 E_md_op = NONE SHALL cause no state change.

Reset
REQ-025 reset at an edge SHALL force IDLE, counter 0, busy 0, hi 0, lo 0, result register 0, abandoning any in-flight operation.
REQ-026 reset SHALL override any simultaneous start or MT* write.

Structure
REQ-027 Opcode encodings, MULT_CYCLES/DIV_CYCLES defaults, and FSM state encodings SHALL live in the shared macros header beside the pipeline stage macros.
REQ-028 The 64-bit arithmetic (signed/unsigned mult, div, rem) SHALL be a combinational sub-module mdu_alu; mdu_ctrl holds the FSM, counter, and HI/LO.
REQ-029 mdu_ctrl SHALL sit in the E stage, with md_stall ORed into the top-level stall signal.

Verification
REQ-030 MULT with rs=0xFFFFFFFE, rt=3 at edge 0 -> busy 1 for edges 0-5; at edge 5 HI=0xFFFFFFFF and LO=0xFFFFFFFA; busy 0 after that edge.
REQ-031 DIVU with rs=17, rt=5 -> busy for 10 cycles, then LO=3 and HI=2; DIV with rs=-7, rt=2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-032 MULT then MFLO in D the next cycle -> md_stall high on the start cycle and every busy cycle, low the cycle after completion, and md_rdata gives the new LO.
REQ-033 DIV with rt=0 after MTHI 0x1234 and MTLO 0x5678 -> after 10 busy cycles HI=0x1234 and LO=0x5678.
REQ-034 reset asserted on cycle 3 of a DIV -> next cycle busy=0, hi=0, lo=0, state IDLE; a following MTLO 9 sets lo=9.
REQ-035 MULTU with rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE and LO=0x00000001; with D_is_md=0 throughout, md_stall stays 0.
